// File: rtl/pcs_8b10b_pkg.sv
// Shared 8b/10b definitions for the 1000BASE-X PCS transmit encoder and receive decoder.
// Sub-block tables hold the RD- form; 'flip' says whether the RD+ form is its complement.
package pcs_8b10b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K29_7 = 8'hFD;

  typedef enum logic {
    RD_NEG = 1'b0,
    RD_POS = 1'b1
  } rd_e;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [9:0] D5_6_RDN  = 10'b1010010110;
  localparam logic [9:0] D5_6_RDP  = 10'b1010010110;
  localparam logic [9:0] K27_7_RDN = 10'b1101101000;
  localparam logic [9:0] K27_7_RDP = 10'b0010010111;
  localparam logic [9:0] K23_7_RDN = 10'b1110101000;
  localparam logic [9:0] K23_7_RDP = 10'b0001010111;
  localparam logic [9:0] K29_7_RDN = 10'b1011101000;
  localparam logic [9:0] K29_7_RDP = 10'b0100010111;

  typedef struct packed {
    logic       flip;
    logic [5:0] code;
  } sub6_t;

  typedef struct packed {
    logic       flip;
    logic [3:0] code;
  } sub4_t;

  // abcdei in RD- form; the neutral 111000 is the only balanced pattern with an RD+ twin
  function automatic sub6_t enc_5b6b(input logic [4:0] x, input logic is_k);
    sub6_t r;
    r.code = 6'b000000;
    if (is_k && x == 5'd28) begin
      r.code = 6'b001111;
    end else begin
      case (x)
        5'd0:  r.code = 6'b100111;
        5'd1:  r.code = 6'b011101;
        5'd2:  r.code = 6'b101101;
        5'd3:  r.code = 6'b110001;
        5'd4:  r.code = 6'b110101;
        5'd5:  r.code = 6'b101001;
        5'd6:  r.code = 6'b011001;
        5'd7:  r.code = 6'b111000;
        5'd8:  r.code = 6'b111001;
        5'd9:  r.code = 6'b100101;
        5'd10: r.code = 6'b010101;
        5'd11: r.code = 6'b110100;
        5'd12: r.code = 6'b001101;
        5'd13: r.code = 6'b101100;
        5'd14: r.code = 6'b011100;
        5'd15: r.code = 6'b010111;
        5'd16: r.code = 6'b011011;
        5'd17: r.code = 6'b100011;
        5'd18: r.code = 6'b010011;
        5'd19: r.code = 6'b110010;
        5'd20: r.code = 6'b001011;
        5'd21: r.code = 6'b101010;
        5'd22: r.code = 6'b011010;
        5'd23: r.code = 6'b111010;
        5'd24: r.code = 6'b110011;
        5'd25: r.code = 6'b100110;
        5'd26: r.code = 6'b010110;
        5'd27: r.code = 6'b110110;
        5'd28: r.code = 6'b001110;
        5'd29: r.code = 6'b101110;
        5'd30: r.code = 6'b011110;
        default: r.code = 6'b101011;
      endcase
    end
    r.flip = ($countones(r.code) != 3) || (r.code == 6'b111000);
    return r;
  endfunction

  // fghj in RD- form; every K column entry has a distinct RD+ form
  function automatic sub4_t enc_3b4b(input logic [2:0] y, input logic is_k, input logic alt7);
    sub4_t r;
    r.code = 4'b0000;
    if (is_k) begin
      case (y)
        3'd0: r.code = 4'b1011;
        3'd1: r.code = 4'b0110;
        3'd2: r.code = 4'b1010;
        3'd3: r.code = 4'b1100;
        3'd4: r.code = 4'b1101;
        3'd5: r.code = 4'b0101;
        3'd6: r.code = 4'b1001;
        default: r.code = 4'b0111;
      endcase
      r.flip = 1'b1;
    end else begin
      case (y)
        3'd0: r.code = 4'b1011;
        3'd1: r.code = 4'b1001;
        3'd2: r.code = 4'b0101;
        3'd3: r.code = 4'b1100;
        3'd4: r.code = 4'b1101;
        3'd5: r.code = 4'b1010;
        3'd6: r.code = 4'b0110;
        default: r.code = alt7 ? 4'b0111 : 4'b1110;
      endcase
      r.flip = ($countones(r.code) != 2) || (r.code == 4'b1100);
    end
    return r;
  endfunction

endpackage

// File: rtl/pcs_enc_8b10b_comb.sv
// Purely combinational 8b/10b encoder: one code group plus running disparity in,
// 10-bit group and updated disparity out; illegal K groups become K28.5.
module pcs_enc_8b10b_comb
  import pcs_8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       is_k,
  input  logic       rd_in,
  output logic [9:0] code_10,
  output logic       rd_out,
  output logic       k_illegal
);

  logic       w_k_legal;
  logic [7:0] w_byte;
  sub6_t      w_six;
  sub4_t      w_four;
  logic [5:0] w_six_code;
  logic [3:0] w_four_code;
  logic       w_rd_mid;
  logic       w_alt7;

  assign w_k_legal = (data[4:0] == 5'd28) ||
                     ((data[7:5] == 3'd7) &&
                      (data[4:0] inside {5'd23, 5'd27, 5'd29, 5'd30}));
  assign k_illegal = is_k & ~w_k_legal;
  assign w_byte    = k_illegal ? K28_5 : data;

  assign w_six      = enc_5b6b(w_byte[4:0], is_k);
  assign w_six_code = (rd_in & w_six.flip) ? ~w_six.code : w_six.code;
  assign w_rd_mid   = rd_in ^ ($countones(w_six.code) != 3);

  // A7 avoids a run of five identical bits across the sub-block boundary
  assign w_alt7 = ~is_k &
                  ((~w_rd_mid & (w_byte[4:0] inside {5'd17, 5'd18, 5'd20})) |
                   ( w_rd_mid & (w_byte[4:0] inside {5'd11, 5'd13, 5'd14})));

  assign w_four      = enc_3b4b(w_byte[7:5], is_k, w_alt7);
  assign w_four_code = (w_rd_mid & w_four.flip) ? ~w_four.code : w_four.code;

  assign code_10 = {w_six_code, w_four_code};
  assign rd_out  = w_rd_mid ^ ($countones(w_four.code) != 2);

endmodule

// File: rtl/pcs_tx_code_group.sv
// 1000BASE-X PCS transmit code-group stage: registers the encoded group, running
// disparity, even/odd slot and ordered-set flags on the falling clock edge.
module pcs_tx_code_group
  import pcs_8b10b_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       power,
  input  logic [7:0] tx_o_set,
  input  logic       tx_is_k,
  output logic [9:0] tx_code_10,
  output logic       tx_rd,
  output logic       tx_even,
  output logic       tx_oset_indicate,
  output logic       tx_code_err
);

  rd_e        r_rd;
  logic [9:0] r_code;
  logic       r_even;
  logic       r_oset;
  logic       r_err;

  logic [9:0] w_code;
  logic       w_rd;
  logic       w_k_illegal;
  logic       w_is_comma;

  pcs_enc_8b10b_comb u_enc (
    .data      (tx_o_set),
    .is_k      (tx_is_k),
    .rd_in     (r_rd),
    .code_10   (w_code),
    .rd_out    (w_rd),
    .k_illegal (w_k_illegal)
  );

  // K28.5 opens an /I/ ordered set, so it never completes one
  assign w_is_comma = (tx_is_k && tx_o_set == K28_5) || w_k_illegal;

  always_ff @(negedge clock) begin
    if (power) begin
      if (reset) begin
        r_code <= 10'b0000000000;
        r_rd   <= RD_NEG;
        r_even <= 1'b0;
        r_oset <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        r_code <= w_code;
        r_rd   <= rd_e'(w_rd);
        r_even <= ~r_even;
        r_oset <= ~w_is_comma;
        r_err  <= w_k_illegal;
      end
    end
  end

  assign tx_code_10       = r_code;
  assign tx_rd            = r_rd;
  assign tx_even          = r_even;
  assign tx_oset_indicate = r_oset;
  assign tx_code_err      = r_err;

endmodule

// File: doc/pcs_tx_code_group.md
# pcs_tx_code_group

Transmit code-group stage of the 1000BASE-X PCS. It sits directly downstream of the transmit ordered-set state machine. Each cycle it takes one 8-bit code group plus a control flag and encodes it to a 10-bit 8b/10b code group, tracking running disparity. It also generates the `tx_even` alternation and `tx_oset_indicate` that the ordered-set machine consumes, and flags illegal control codes.

## Interface
- No parameters.
- `clock`  in  1  PCS clock; all state updates on the falling edge.
- `reset`  in  1  reset, synchronous, active-high; effective only while `power`=1.
- `power`  in  1  block enable; while 0, every register holds its value.
- `tx_o_set`  in  8  code group to encode, HGF EDCBA, bit 7 = H.
- `tx_is_k`  in  1  1 = control code group (Kx.y), 0 = data (Dx.y).
- `tx_code_10`  out  10  encoded group abcdei fghj; bit 9 = a, bit 0 = j.
- `tx_rd`  out  1  running disparity after `tx_code_10`; 0 = RD−, 1 = RD+.
- `tx_even`  out  1  1 when `tx_code_10` occupies an even slot.
- `tx_oset_indicate`  out  1  1 when the group on `tx_code_10` completes an ordered set.
- `tx_code_err`  out  1  1 when the group on `tx_code_10` replaced an illegal K input.

## Operation
- Standard IEEE 802.3 clause 36 8b/10b encoding:
  - 5b/6b and 3b/4b sub-block tables.
  - RD− column is used when the current disparity is negative.
  - Disparity is updated after the 6b sub-block, and again after the 4b sub-block.
- Sub-block disparity rule: a non-neutral sub-block flips RD. For the neutral 6b patterns 111000/000111 and the 4b patterns 1100/0011, the form is chosen by RD.
- D.x.7 alternate encoding (A7, 0111/1000) is used when:
  - RD− and x ∈ {17, 18, 20}, or
  - RD+ and x ∈ {11, 13, 14}.
  - Otherwise P7 (1110/0001) is used.
- K groups:
  - K28.y uses the K-specific 3b/4b column.
  - Legal K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7.
- Illegal K input handling:
  - Encode K28.5 with the current RD.
  - Assert `tx_code_err` for that group.
  - RD updates as for K28.5.
- No idle disparity correction (D5.6/D16.2 substitution) is performed here; the input is encoded literally.
- `tx_oset_indicate`:
  - 0 when the emitted group is K28.5 (first half of /I/, or an illegal-K substitute).
  - 1 for every other group.
- `tx_even` toggles on every active edge.
- Reset values:
  - `tx_code_10` = 10'b0000000000.
  - RD = 0 (RD−), so `tx_rd` = 0.
  - `tx_even` = 0.
  - `tx_oset_indicate` = 0.
  - `tx_code_err` = 0.
- Reset mid-stream discards the in-flight group and restores RD−. The first group after reset is encoded from RD− and has `tx_even` = 1.

## Timing
- Inputs are sampled on falling edge N. All outputs for that group are registered and become valid immediately after edge N: one-cycle latency, no bubbles.
- One group in, one group out per active cycle. There is no handshake; the upstream stage must present a new group every cycle.
- `power` = 0 at edge N: inputs are ignored, and outputs and RD are unchanged.
- `reset` = 1 together with `power` = 1 overrides the input group at the same edge.
- Encode logic is purely combinational from (`tx_o_set`, `tx_is_k`, RD register) to the output registers.

## Structure
- Shared package `pcs_8b10b_pkg`:
  - 8-bit code group constants: K28_5 = 8'hBC, D5_6 = 8'hC5, K27_7 = 8'hFB, K23_7 = 8'hF7, K29_7 = 8'hFD.
  - RD encoding constants.
  - 10-bit RD−/RD+ forms of the above.
  - The same package is reused by the receive decoder.
- One combinational sub-module, `pcs_enc_8b10b_comb`, with:
  - Inputs: data, is_k, rd_in.
  - Outputs: code_10, rd_out, k_illegal.
- The top level holds the RD, `tx_even`, output and flag registers.

## Test plan
1. Reset, then K28.5 followed by D5.6 (`tx_is_k` = 1 then 0):
   - Outputs 0011111010, then 1010010110.
   - `tx_rd` = 1 after both groups.
   - `tx_oset_indicate` = 0, then 1.
   - `tx_even` = 1, then 0.
2. From RD+, K28.5 → 1100000101, `tx_rd` = 0. Next D0.0 → 1001110100, `tx_rd` = 0.
3. From RD−:
   - D3.0 → 1100011011, `tx_rd` = 1.
   - Then D3.0 again → 1100010100, `tx_rd` = 0.
4. A7 selection:
   - From RD−, D17.7 (8'hF1) → 1000110111.
   - From RD+, D11.7 (8'hEB) → 1101001000.
5. Illegal K (8'h00, `tx_is_k` = 1) at RD− → 0011111010, `tx_code_err` = 1 for one cycle, `tx_rd` = 1.
6. Hold and reset:
   - `power` = 0 for 3 cycles mid-stream: all outputs are frozen.
   - Then `reset` = 1 with `power` = 1 for one edge: all outputs go to their reset values.
   - The next K23.7 → 1110101000, `tx_rd` = 0.
